// File: rtl/mem_bridge.sv
// mem_bridge: bridges 65c816 byte/word memory requests onto the test RAM's
// req_rdwr/data_ready handshake. A 16-bit access becomes two byte
// transactions (low byte first) separated by one cycle with req_rdwr low.
// Optional build macro: MEM_BRIDGE_TIMEOUT_EN (WAIT abort after TIMEOUT_CYCLES).
module mem_bridge #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req_i,
  input  logic                    cpu_we_i,
  input  logic                    cpu_wide_i,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr_i,
  input  logic [2*DATA_WIDTH-1:0] cpu_wdata_i,
  output logic [2*DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                    cpu_busy_o,
  output logic                    cpu_done_o,
  output logic                    cpu_err_o,
  output logic                    mem_req_rdwr_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_data_in_o,
  input  logic [DATA_WIDTH-1:0]   mem_data_out_i,
  input  logic                    mem_data_ready_i
);

  localparam int unsigned WW = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic                  idx_q, idx_d;
  logic                  we_q, we_d;
  logic                  wide_q, wide_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [WW-1:0]         wdata_q, wdata_d;
  logic [WW-1:0]         rbuf_q, rbuf_d;

  // Registered outputs
  logic                  req_q, req_d;
  logic                  mwe_q, mwe_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] mdin_q, mdin_d;
  logic [WW-1:0]         rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_d;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;
`endif

  // Next-state, latch and output decode; outputs are computed from the next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wide_d  = wide_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req_i) begin
          base_d  = cpu_addr_i;
          wdata_d = cpu_wdata_i;
          we_d    = cpu_we_i;
          wide_d  = cpu_wide_i;
          idx_d   = 1'b0;
          rbuf_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef MEM_BRIDGE_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_data_ready_i) begin
          if (!we_q) begin
            if (idx_q) rbuf_d[WW-1:DATA_WIDTH] = mem_data_out_i;
            else       rbuf_d[DATA_WIDTH-1:0]  = mem_data_out_i;
          end
          if (wide_q && !idx_q) begin
            idx_d   = 1'b1;
            state_d = S_GAP;
          end else begin
            if (!we_q) rdata_d = rbuf_d;
            state_d = S_DONE;
          end
        end
`ifdef MEM_BRIDGE_TIMEOUT_EN
        else if ((cnt_q + CW'(1)) == CW'(TIMEOUT_CYCLES)) begin
          // Abort: skip any remaining byte, keep previous read data
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_GAP:   state_d = S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_d   = (state_d == S_ISSUE) || (state_d == S_WAIT);
    mwe_d   = (state_d == S_ISSUE) && we_d;
    maddr_d = maddr_q;
    mdin_d  = mdin_q;
    if (state_d == S_ISSUE) begin
      maddr_d = base_d + ADDR_WIDTH'(idx_d);
      mdin_d  = idx_d ? wdata_d[WW-1:DATA_WIDTH] : wdata_d[DATA_WIDTH-1:0];
    end
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State, latches and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 1'b0;
      we_q    <= 1'b0;
      wide_q  <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      req_q   <= 1'b0;
      mwe_q   <= 1'b0;
      maddr_q <= '0;
      mdin_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wide_q  <= wide_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      req_q   <= req_d;
      mwe_q   <= mwe_d;
      maddr_q <= maddr_d;
      mdin_q  <= mdin_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign mem_req_rdwr_o = req_q;
  assign mem_we_o       = mwe_q;
  assign mem_addr_o     = maddr_q;
  assign mem_data_in_o  = mdin_q;
  assign cpu_rdata_o    = rdata_q;
  assign cpu_busy_o     = busy_q;
  assign cpu_done_o     = done_q;
`ifdef MEM_BRIDGE_TIMEOUT_EN
  assign cpu_err_o      = err_q;
`else
  // err_d is only ever 0 without the timeout; keep it referenced for lint
  assign cpu_err_o      = err_d & 1'b0;
`endif

endmodule

// File: tb/tb_mem_bridge.sv
// Testbench for mem_bridge: RAM model with fixed 2-edge ready, reference byte
// memory, and a scoreboard checked by an independent done monitor.
module tb_mem_bridge;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_wide = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_busy, cpu_done, cpu_err;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_rdy;

  logic [7:0]  ram [0:65535];
  logic        ram_rdy = 1'b0;
  int          ram_cnt = 0;
  logic        block = 1'b0;

  typedef struct {
    logic [15:0] rdata;
    bit          err;
    int          acc;
    int          lat;
    int          we_n;
    int          gap_n;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] last_rd = '0;
  int          cyc = 0;
  int          checks = 0, errors = 0;
  int          we_c = 0, gap_c = 0;
  bit          prev_hold = 0;
  int          prev_acc = 0, prev_lat = 0;

  assign mem_rdy = ram_rdy & ~block;

  mem_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_wide_i(cpu_wide),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_busy_o(cpu_busy), .cpu_done_o(cpu_done),
    .cpu_err_o(cpu_err),
    .mem_req_rdwr_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_data_in_o(mem_din), .mem_data_out_i(mem_dout), .mem_data_ready_i(mem_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: writes whenever we=1, ready after two edges of req, cleared by req=0
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    mem_dout = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
      if (!mem_req) begin
        ram_cnt <= 0;
        ram_rdy <= 1'b0;
      end else begin
        if (ram_cnt < 2) ram_cnt <= ram_cnt + 1;
        if (ram_cnt == 1) ram_rdy <= 1'b1;
      end
    end
  end

  // Monitor: pops an expectation on every cpu_done pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      we_c  <= 0;
      gap_c <= 0;
    end else if (cpu_done) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got done=1 want no completion");
      end else begin
        exp_t e;
        int lat;
        e = q.pop_front();
        lat = cyc - e.acc + 1;
        if (cpu_rdata !== e.rdata) begin
          errors++; $display("FAIL rdata got %h want %h", cpu_rdata, e.rdata);
        end
        checks++;
        if (cpu_err !== e.err) begin
          errors++; $display("FAIL err got %b want %b", cpu_err, e.err);
        end
        checks++;
        if (lat != e.lat) begin
          errors++; $display("FAIL latency got %0d want %0d", lat, e.lat);
        end
        checks++;
        if (we_c != e.we_n) begin
          errors++; $display("FAIL we_cycles got %0d want %0d", we_c, e.we_n);
        end
        checks++;
        if (gap_c != e.gap_n) begin
          errors++; $display("FAIL gap_cycles got %0d want %0d", gap_c, e.gap_n);
        end
      end
      we_c  <= 0;
      gap_c <= 0;
    end else begin
      if (cpu_busy && mem_we) we_c <= we_c + 1;
      if (cpu_busy && !mem_req) gap_c <= gap_c + 1;
    end
  end

  // Issue one access; the expectation comes from the reference byte memory
  task automatic access(input bit we, input bit wide, input logic [15:0] addr,
                        input logic [15:0] wd, input bit hold, input bit tmo,
                        input bit push);
    int n;
    exp_t e;
    logic [15:0] a1;
    n = 0;
    @(negedge clk);
    while (cpu_busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL idle_wait got busy=%b want 0 within 300 cycles", cpu_busy);
      return;
    end
    cpu_we = we; cpu_wide = wide; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (cpu_busy !== 1'b1) begin
      errors++; $display("FAIL accept got busy=%b want 1", cpu_busy);
    end
    a1 = addr + 16'd1;
    e.acc   = cyc;
    e.err   = tmo;
    e.lat   = tmo ? T + 2 : (wide ? 8 : 4);
    e.gap_n = (wide && !tmo) ? 1 : 0;
    e.we_n  = we ? (wide ? 2 : 1) : 0;
    if (we) begin
      ref_mem[addr] = wd[7:0];
      if (wide) ref_mem[a1] = wd[15:8];
      e.rdata = last_rd;
    end else if (tmo) begin
      e.rdata = last_rd;
    end else begin
      e.rdata = {wide ? ref_mem[a1] : 8'h00, ref_mem[addr]};
      last_rd = e.rdata;
    end
    if (prev_hold) begin
      checks++;
      if (e.acc - prev_acc != prev_lat + 1) begin
        errors++;
        $display("FAIL b2b_spacing got %0d want %0d", e.acc - prev_acc, prev_lat + 1);
      end
    end
    prev_hold = hold; prev_acc = e.acc; prev_lat = e.lat;
    if (push) q.push_back(e);
    if (!hold) begin
      cpu_req = 1'b0;
      cpu_we = 1'($urandom); cpu_wide = 1'($urandom);
      cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({cpu_rdata, cpu_busy, cpu_done, cpu_err, mem_req, mem_we, mem_addr, mem_din} !== '0) begin
      errors++;
      $display("FAIL %s got rdata=%h busy=%b done=%b err=%b req=%b we=%b addr=%h din=%h want all 0",
               name, cpu_rdata, cpu_busy, cpu_done, cpu_err, mem_req, mem_we, mem_addr, mem_din);
    end
  endtask

  initial begin
    bit bad;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;

    // Directed cases
    access(1, 0, 16'h0010, 16'h00A5, 0, 0, 1);
    access(0, 0, 16'h0010, 16'h0000, 0, 0, 1);
    access(1, 1, 16'h0020, 16'hBEEF, 0, 0, 1);
    access(0, 0, 16'h0020, 16'h0000, 0, 0, 1);
    access(0, 0, 16'h0021, 16'h0000, 0, 0, 1);
    access(0, 1, 16'h0020, 16'h0000, 0, 0, 1);
    access(1, 1, 16'hFFFF, 16'h1234, 0, 0, 1);
    access(0, 0, 16'hFFFF, 16'h0000, 0, 0, 1);
    access(0, 0, 16'h0000, 16'h0000, 0, 0, 1);
    access(0, 1, 16'hFFFF, 16'h0000, 0, 0, 1);

    // Back-to-back with cpu_req held high
    access(1, 0, 16'h0030, 16'h0011, 1, 0, 1);
    access(1, 0, 16'h0031, 16'h0022, 1, 0, 1);
    access(0, 0, 16'h0030, 16'h0000, 0, 0, 1);
    drain();

    // Reset during WAIT of a 16-bit read
    access(0, 1, 16'h0020, 16'h0000, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_access");
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
    prev_hold = 0;
    access(0, 0, 16'h0010, 16'h0000, 0, 0, 1);
    drain();

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ad;
      ad = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'h0040 + 16'($urandom_range(0, 7));
      access(1'($urandom), 1'($urandom), ad, 16'($urandom), 0, 0, 1);
    end
    drain();

    // Ready never arrives
    block = 1'b1;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    access(0, 1, 16'h0040, 16'h0000, 0, 1, 1);
    drain();
    block = 1'b0;
    access(0, 0, 16'h0010, 16'h0000, 0, 0, 1);
    drain();
`else
    access(0, 0, 16'h0010, 16'h0000, 0, 0, 0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (cpu_busy !== 1'b1 || cpu_err !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stuck_wait got busy=%b err=%b want busy=1 err=0", cpu_busy, cpu_err);
    end
    rst_n = 1'b0;
    block = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
    access(0, 0, 16'h0010, 16'h0000, 0, 0, 1);
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
